// File: rtl/poly_tone_i2s.sv
// Polyphonic square-wave tone generator with stepped volume and a left-justified
// serial audio output: VOICES dividers are mixed, saturated and sent once per 512-clk frame.
module poly_tone_i2s #(
    parameter int VOICES     = 3,
    parameter int DIV_W      = 22,
    parameter int VOL_LEVELS = 16,
    parameter int VOL_RESET  = 8,
    parameter int AMP_STEP   = 16'h0800,
    parameter int SAMPLE_W   = 16,
    parameter int LVL_W      = $clog2(VOL_LEVELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VOICES*DIV_W-1:0] note_div,
    input  logic [VOICES-1:0]       voice_en,
    input  logic                    vol_up,
    input  logic                    vol_down,
    output logic [LVL_W-1:0]        vol_level,
    output logic                    clip,
    output logic                    audio_mclk,
    output logic                    audio_lrclk,
    output logic                    audio_sclk,
    output logic                    audio_sdin
);

    localparam int MIX_W = SAMPLE_W + $clog2(VOICES) + 1;
    localparam int SHR_W = 2 * SAMPLE_W;
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(VOL_LEVELS - 1);
    localparam logic [LVL_W-1:0] LVL_RST = LVL_W'(VOL_RESET);
    localparam logic signed [MIX_W-1:0] MAX_S = {{(MIX_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [MIX_W-1:0] MIN_S = ~MAX_S;

    logic [8:0]              cnt_r;
    logic [SHR_W-1:0]        shreg_r;
    logic                    clip_r;
    logic [LVL_W-1:0]        vol_level_r;
    logic [VOICES-1:0]       active_s;
    logic [VOICES-1:0]       phase_s;
    logic [SAMPLE_W-1:0]     amp_s;
    logic signed [MIX_W-1:0] amp_ext_s;
    logic signed [MIX_W-1:0] mix_s;
    logic [SAMPLE_W-1:0]     sample_s;
    logic                    sat_s;

    for (genvar gv = 0; gv < VOICES; gv++) begin : g_voice
        logic [DIV_W-1:0] div_s;
        logic [DIV_W-1:0] vcnt_r;
        logic             phase_r;

        assign div_s        = note_div[gv*DIV_W +: DIV_W];
        assign active_s[gv] = voice_en[gv] && (div_s != {DIV_W{1'b0}});
        assign phase_s[gv]  = phase_r;

        // Half-period counter; ">=" lets a lowered divider wrap on the next clk.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vcnt_r  <= {DIV_W{1'b0}};
                phase_r <= 1'b0;
            end else if (!active_s[gv]) begin
                vcnt_r  <= {DIV_W{1'b0}};
                phase_r <= 1'b0;
            end else if (vcnt_r >= (div_s - DIV_ONE)) begin
                vcnt_r  <= {DIV_W{1'b0}};
                phase_r <= ~phase_r;
            end else begin
                vcnt_r  <= vcnt_r + DIV_ONE;
                phase_r <= phase_r;
            end
        end
    end

    // Volume level, saturating at both ends; simultaneous up/down cancels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vol_level_r <= LVL_RST;
        end else if (vol_up && !vol_down && (vol_level_r != LVL_MAX)) begin
            vol_level_r <= vol_level_r + {{(LVL_W-1){1'b0}}, 1'b1};
        end else if (vol_down && !vol_up && (vol_level_r != {LVL_W{1'b0}})) begin
            vol_level_r <= vol_level_r - {{(LVL_W-1){1'b0}}, 1'b1};
        end else begin
            vol_level_r <= vol_level_r;
        end
    end

    assign amp_s     = SAMPLE_W'(vol_level_r * AMP_STEP);
    assign amp_ext_s = signed'({{(MIX_W-SAMPLE_W){1'b0}}, amp_s});

    // Signed sum of the active voices at the common amplitude.
    always_comb begin
        mix_s = {MIX_W{1'b0}};
        for (int v = 0; v < VOICES; v++) begin
            if (active_s[v]) begin
                if (phase_s[v]) begin
                    mix_s = mix_s + amp_ext_s;
                end else begin
                    mix_s = mix_s - amp_ext_s;
                end
            end else begin
                mix_s = mix_s;
            end
        end
    end

    // Clamp the mix into the signed sample range and flag the clamp.
    always_comb begin
        sample_s = mix_s[SAMPLE_W-1:0];
        sat_s    = 1'b0;
        if (mix_s > MAX_S) begin
            sample_s = MAX_S[SAMPLE_W-1:0];
            sat_s    = 1'b1;
        end else if (mix_s < MIN_S) begin
            sample_s = MIN_S[SAMPLE_W-1:0];
            sat_s    = 1'b1;
        end else begin
            sample_s = mix_s[SAMPLE_W-1:0];
            sat_s    = 1'b0;
        end
    end

    // Frame counter, sample latch at the last frame cycle, and MSB-first shifter.
    // The shift skips the latch cycle so the fresh sample is not shifted immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= 9'h000;
            shreg_r <= {SHR_W{1'b0}};
            clip_r  <= 1'b0;
        end else begin
            cnt_r <= cnt_r + 9'h001;
            if (cnt_r == 9'h1FF) begin
                shreg_r <= {sample_s, sample_s};
                clip_r  <= sat_s;
            end else begin
                clip_r <= 1'b0;
                if (cnt_r[3:0] == 4'hF) begin
                    shreg_r <= {shreg_r[SHR_W-2:0], 1'b0};
                end else begin
                    shreg_r <= shreg_r;
                end
            end
        end
    end

    assign vol_level   = vol_level_r;
    assign clip        = clip_r;
    assign audio_mclk  = cnt_r[1];
    assign audio_sclk  = cnt_r[3];
    assign audio_lrclk = cnt_r[8];
    assign audio_sdin  = shreg_r[SHR_W-1];

endmodule

// File: tb/tb_poly_tone_i2s.sv
// Bench for poly_tone_i2s: integer-arithmetic reference model compared every cycle,
// directed scenarios with literal expectations, then randomized voice/volume traffic.
module tb_poly_tone_i2s;

    localparam int VOICES = 3;
    localparam int DIV_W  = 22;
    localparam int LVL_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [VOICES*DIV_W-1:0] note_div = '0;
    logic [VOICES-1:0]       voice_en = '0;
    logic                    vol_up = 1'b0;
    logic                    vol_down = 1'b0;
    logic [LVL_W-1:0]        vol_level;
    logic                    clip, audio_mclk, audio_lrclk, audio_sclk, audio_sdin;

    poly_tone_i2s dut (
        .clk(clk), .rst(rst), .note_div(note_div), .voice_en(voice_en),
        .vol_up(vol_up), .vol_down(vol_down), .vol_level(vol_level), .clip(clip),
        .audio_mclk(audio_mclk), .audio_lrclk(audio_lrclk),
        .audio_sclk(audio_sclk), .audio_sdin(audio_sdin)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state (plain integers)
    int          m_cnt;
    logic [31:0] m_shreg;
    logic        m_clip;
    int          m_vol;
    int          m_vcnt [VOICES];
    bit          m_ph   [VOICES];

    logic [15:0] dut_word = '0;
    logic [15:0] last_word = '0;
    int          word_ready = 0;
    int          clip_seen = 0;

    function automatic int get_div(int v);
        return int'(note_div[v*DIV_W +: DIV_W]);
    endfunction

    task automatic set_div(int v, int d);
        note_div[v*DIV_W +: DIV_W] = DIV_W'(d);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_shreg = '0; m_clip = 1'b0; m_vol = 8;
        for (int v = 0; v < VOICES; v++) begin
            m_vcnt[v] = 0; m_ph[v] = 1'b0;
        end
    endtask

    task automatic model_advance();
        int mix, amp, s, d;
        bit sat, act;
        amp = m_vol * 2048;
        mix = 0;
        for (int v = 0; v < VOICES; v++) begin
            d = get_div(v);
            act = voice_en[v] && (d != 0);
            if (act) mix += m_ph[v] ? amp : -amp;
        end
        sat = (mix > 32767) || (mix < -32768);
        s = (mix > 32767) ? 32767 : ((mix < -32768) ? -32768 : mix);
        if (m_cnt == 511) begin
            m_shreg = {s[15:0], s[15:0]};
            m_clip  = sat;
        end else begin
            m_clip = 1'b0;
            if (m_cnt % 16 == 15) m_shreg = m_shreg << 1;
        end
        for (int v = 0; v < VOICES; v++) begin
            d = get_div(v);
            if (voice_en[v] && d != 0) begin
                if (m_vcnt[v] >= d - 1) begin
                    m_vcnt[v] = 0; m_ph[v] = !m_ph[v];
                end else begin
                    m_vcnt[v] = m_vcnt[v] + 1;
                end
            end else begin
                m_vcnt[v] = 0; m_ph[v] = 1'b0;
            end
        end
        if (vol_up && !vol_down && m_vol < 15) m_vol++;
        else if (vol_down && !vol_up && m_vol > 0) m_vol--;
        m_cnt = (m_cnt + 1) % 512;
    endtask

    task automatic check_outputs();
        logic [8:0] c;
        logic [3:0] lv;
        c  = 9'(m_cnt);
        lv = LVL_W'(m_vol);
        vectors++;
        if (audio_mclk !== c[1] || audio_sclk !== c[3] || audio_lrclk !== c[8] ||
            audio_sdin !== m_shreg[31] || clip !== m_clip || vol_level !== lv) begin
            miscompares++;
            $display("FAIL pins @cnt=%0d t=%0t: mclk/sclk/lrclk/sdin/clip=%b%b%b%b%b vol=%0d, required %b%b%b%b%b vol=%0d",
                     m_cnt, $time, audio_mclk, audio_sclk, audio_lrclk, audio_sdin, clip, vol_level,
                     c[1], c[3], c[8], m_shreg[31], m_clip, lv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_advance();
        #1;
        check_outputs();
        if (clip === 1'b1) clip_seen++;
        if (m_cnt < 256 && m_cnt % 16 == 8) begin
            dut_word = {dut_word[14:0], audio_sdin};
            if (m_cnt == 248) begin
                last_word = dut_word;
                word_ready++;
            end
        end
    endtask

    task automatic expect_lit(string name, int got, int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic expect_word(string name, logic [15:0] w, logic [15:0] a, logic [15:0] b);
        vectors++;
        if (w !== a && w !== b) begin
            miscompares++;
            $display("FAIL %s: got word 0x%04h, required 0x%04h or 0x%04h", name, w, a, b);
        end
    endtask

    task automatic run_frames(string name, int n_frames, logic [15:0] a, logic [15:0] b,
                              output int na, output int nb);
        int prev;
        prev = word_ready; na = 0; nb = 0;
        for (int i = 0; i < n_frames * 512; i++) begin
            step();
            if (word_ready != prev) begin
                prev = word_ready;
                expect_word(name, last_word, a, b);
                if (last_word == a) na++;
                if (last_word == b) nb++;
            end
        end
    endtask

    task automatic pulse_vol(bit up, bit down);
        vol_up = up; vol_down = down;
        step();
        vol_up = 1'b0; vol_down = 1'b0;
        step();
    endtask

    initial begin
        int na, nb, ones, guard, r;

        // reset state
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs();
        expect_lit("reset_vol", int'(vol_level), 8);
        @(negedge clk);
        rst = 1'b1;

        // idle: clocks only, sdin silent
        repeat (1600) step();
        expect_lit("idle_word", int'(last_word), 0);

        // single voice, divider 4, level 8
        set_div(0, 4); voice_en = 3'b001;
        repeat (1100) step();
        run_frames("v0_div4_word", 3, 16'h4000, 16'hC000, na, nb);
        expect_lit("v0_div4_words_seen", na + nb, 3);

        // level 15, three voices on the same cycle: saturation both ways
        voice_en = 3'b000;
        repeat (7) pulse_vol(1'b1, 1'b0);
        expect_lit("vol_at_15", int'(vol_level), 15);
        set_div(0, 1000); set_div(1, 1000); set_div(2, 1000);
        voice_en = 3'b111;
        clip_seen = 0;
        repeat (1100) step();
        run_frames("sat_word", 6, 16'h7FFF, 16'h8000, na, nb);
        expect_lit("sat_pos_seen", int'(na > 0), 1);
        expect_lit("sat_neg_seen", int'(nb > 0), 1);
        expect_lit("clip_seen", int'(clip_seen > 0), 1);

        // volume limits and cancelling pulses
        voice_en = 3'b000;
        repeat (20) pulse_vol(1'b1, 1'b0);
        expect_lit("vol_top", int'(vol_level), 15);
        repeat (20) pulse_vol(1'b0, 1'b1);
        expect_lit("vol_bottom", int'(vol_level), 0);
        repeat (5) pulse_vol(1'b1, 1'b0);
        pulse_vol(1'b1, 1'b1);
        expect_lit("vol_up_down", int'(vol_level), 5);

        // voice 1 divider lowered mid-count, then silenced by divider 0
        set_div(1, 100); voice_en = 3'b010;
        guard = 0;
        while (m_vcnt[1] != 50 && guard < 300) begin step(); guard++; end
        expect_lit("reach_cnt50", int'(guard < 300), 1);
        set_div(1, 3);
        step();
        expect_lit("wrap_cnt", m_vcnt[1], 0);
        repeat (1100) step();
        expect_word("div3_word", last_word, 16'h2800, 16'hD800);
        set_div(1, 0);
        repeat (1100) step();
        expect_lit("div0_word", int'(last_word), 0);

        // reset mid-frame while a nonzero sample is shifting
        set_div(0, 4); voice_en = 3'b001;
        repeat (1024) step();
        guard = 0;
        while (m_cnt != 200 && guard < 600) begin step(); guard++; end
        expect_lit("reach_cnt200", int'(guard < 600), 1);
        expect_lit("shifting_nonzero", int'(m_shreg != 32'h0), 1);
        rst = 1'b0;
        model_reset();
        #1 check_outputs();
        expect_lit("midreset_vol", int'(vol_level), 8);
        repeat (3) step();
        rst = 1'b1;
        ones = 0;
        for (int i = 0; i < 511; i++) begin
            step();
            if (audio_sdin === 1'b1) ones++;
        end
        expect_lit("post_reset_silent", ones, 0);

        // randomized voices, dividers and volume pulses
        for (int i = 0; i < 30 * 512; i++) begin
            vol_up = 1'b0; vol_down = 1'b0;
            r = $urandom_range(0, 199);
            if (r == 0) vol_up = 1'b1;
            else if (r == 1) vol_down = 1'b1;
            else if (r == 2) begin vol_up = 1'b1; vol_down = 1'b1; end
            else if (r < 5) voice_en = VOICES'($urandom);
            else if (r < 8) begin
                case ($urandom_range(0, 3))
                    0: set_div($urandom_range(0, VOICES - 1), 0);
                    1: set_div($urandom_range(0, VOICES - 1), $urandom_range(1, 5));
                    default: set_div($urandom_range(0, VOICES - 1), $urandom_range(1, 1500));
                endcase
            end
            step();
        end
        vol_up = 1'b0; vol_down = 1'b0;
        repeat (600) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
